// File: rtl/crc_stream.sv
// Parametrised DW-bit-per-beat CRC engine on a valid/ready stream with first/last framing,
// optional input/output reflection, a held result and a residue check for appended-CRC frames.
module crc_stream #(
   parameter int              BITS    = 8,
   parameter int              DW      = 8,
   parameter logic [BITS-1:0] POLY    = 8'h9B,
   parameter logic [BITS-1:0] INIT    = 8'h00,
   parameter bit              REF_IN  = 1'b1,
   parameter bit              REF_OUT = 1'b1,
   parameter logic [BITS-1:0] XOR_OUT = 8'h00,
   parameter logic [BITS-1:0] RESIDUE = 8'h00
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   input  logic            s_first,
   input  logic            s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [BITS-1:0] crc_out,
   output logic            crc_match,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [BITS-1:0] crc_r, crc_s;
   logic [BITS-1:0] seed_s, beat_s, view_s;
   logic [BITS-1:0] crc_out_r, crc_out_s;
   logic            crc_match_r, crc_match_s;
   logic            accept_s, consume_s;

   // All DW serial steps of one beat, unrolled; bit order follows REF_IN.
   function automatic logic [BITS-1:0] crc_beat(input logic [BITS-1:0] seed,
                                                input logic [DW-1:0]   data);
      logic [BITS-1:0] r;
      logic            b;
      logic            fb;
      r = seed;
      for (int i = 0; i < DW; i++) begin
         b  = REF_IN ? data[i] : data[DW-1-i];
         fb = r[BITS-1] ^ b;
         r  = (r << 1) ^ (fb ? POLY : {BITS{1'b0}});
      end
      return r;
   endfunction

   function automatic logic [BITS-1:0] out_view(input logic [BITS-1:0] v);
      logic [BITS-1:0] r;
      for (int i = 0; i < BITS; i++) begin
         r[i] = REF_OUT ? v[BITS-1-i] : v[i];
      end
      return r;
   endfunction

   assign m_valid   = (state_r == ST_DONE);
   assign busy      = (state_r == ST_RUN);
   assign s_ready   = !m_valid || m_ready;
   assign crc_out   = crc_out_r;
   assign crc_match = crc_match_r;
   assign accept_s  = s_valid && s_ready;
   assign consume_s = m_valid && m_ready;

   // Beat datapath: a beat taken outside RUN (including DONE with a same-cycle consume) or
   // carrying s_first starts from INIT, which also silently drops any partial frame.
   always_comb begin
      seed_s      = crc_r;
      crc_s       = crc_r;
      crc_out_s   = crc_out_r;
      crc_match_s = crc_match_r;
      if (s_first || (state_r != ST_RUN)) begin
         seed_s = INIT;
      end else begin
         seed_s = crc_r;
      end
      beat_s = crc_beat(seed_s, s_data);
      view_s = out_view(beat_s);
      if (accept_s) begin
         crc_s = beat_s;
         if (s_last) begin
            crc_out_s   = view_s ^ XOR_OUT;
            crc_match_s = (view_s == RESIDUE);
         end else begin
            crc_out_s   = crc_out_r;
            crc_match_s = crc_match_r;
         end
      end else begin
         crc_s = crc_r;
      end
   end

   // Frame state next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_RUN: begin
            if (accept_s) begin
               state_s = s_last ? ST_DONE : ST_RUN;
            end else begin
               state_s = state_r;
            end
         end
         ST_DONE: begin
            if (accept_s) begin
               state_s = s_last ? ST_DONE : ST_RUN;
            end else if (consume_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, CRC register and held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         crc_r       <= INIT;
         crc_out_r   <= out_view(INIT) ^ XOR_OUT;
         crc_match_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         crc_r       <= crc_s;
         crc_out_r   <= crc_out_s;
         crc_match_r <= crc_match_s;
      end
   end

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: CRC-8/WCDMA, CRC-32 (with residue check) and XMODEM in
// DW=16 and DW=8 builds, plus backpressure, framing corner cases and async reset.
module tb_crc_stream;

   typedef struct {
      int          id;
      logic [63:0] crc;
      logic        match;
      bit          ck_crc;
      bit          ck_match;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  sv, sr, mv, cm, bz;
   logic        m_ready;
   logic [7:0]  d8;
   logic [15:0] d16;
   logic        sf, sl;
   logic [7:0]  co0;
   logic [31:0] co1;
   logic [15:0] co2, co3;

   exp_t        sb[$];
   logic [7:0]  fb[$];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   crc_stream u0 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(d8),
      .s_first(sf), .s_last(sl), .m_valid(mv[0]), .m_ready(m_ready),
      .crc_out(co0), .crc_match(cm[0]), .busy(bz[0])
   );

   crc_stream #(
      .BITS(32), .DW(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REF_IN(1'b1),
      .REF_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .RESIDUE(32'hDEBB20E3)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(d8),
      .s_first(sf), .s_last(sl), .m_valid(mv[1]), .m_ready(m_ready),
      .crc_out(co1), .crc_match(cm[1]), .busy(bz[1])
   );

   crc_stream #(
      .BITS(16), .DW(16), .POLY(16'h1021), .INIT(16'h0000), .REF_IN(1'b0),
      .REF_OUT(1'b0), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
   ) u2 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(d16),
      .s_first(sf), .s_last(sl), .m_valid(mv[2]), .m_ready(m_ready),
      .crc_out(co2), .crc_match(cm[2]), .busy(bz[2])
   );

   crc_stream #(
      .BITS(16), .DW(8), .POLY(16'h1021), .INIT(16'h0000), .REF_IN(1'b0),
      .REF_OUT(1'b0), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
   ) u3 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[3]), .s_ready(sr[3]), .s_data(d8),
      .s_first(sf), .s_last(sl), .m_valid(mv[3]), .m_ready(m_ready),
      .crc_out(co3), .crc_match(cm[3]), .busy(bz[3])
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference models in the classical byte-oriented formulations.
   function automatic logic [7:0] m_crc8();
      logic [7:0] c = 8'h00;
      foreach (fb[i]) begin
         c = c ^ fb[i];
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 8'hD9) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] m_crc32();
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (fb[i]) begin
         c = c ^ {24'h0, fb[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic [15:0] m_xmodem();
      logic [15:0] c = 16'h0000;
      foreach (fb[i]) begin
         c = c ^ {fb[i], 8'h00};
         for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   task automatic load_str(input string s);
      fb.delete();
      for (int i = 0; i < s.len(); i++) fb.push_back(s[i]);
   endtask

   task automatic push_exp(input int id, input logic [63:0] crc, input logic match,
                           input bit ck_crc, input bit ck_match);
      exp_t e;
      e.id = id; e.crc = crc; e.match = match; e.ck_crc = ck_crc; e.ck_match = ck_match;
      sb.push_back(e);
   endtask

   task automatic send_beat(input int sel, input logic [15:0] d, input logic f, input logic l);
      int w = 0;
      d8 = d[7:0]; d16 = d; sf = f; sl = l;
      sv = 4'b0000; sv[sel] = 1'b1;
      while (!sr[sel] && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!sr[sel]) begin
         check_eq("ready_timeout", 64'(sr[sel]), 64'd1);
      end else begin
         @(posedge clk); #1;
         if (l) check_eq("latency_mvalid", 64'(mv[sel]), 64'd1);
      end
      sv = 4'b0000;
   endtask

   task automatic send_bytes(input int sel, input bit f, input bit l);
      foreach (fb[i]) send_beat(sel, {8'h00, fb[i]}, f && (i == 0), l && (i == fb.size() - 1));
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_eq("drain_empty", 64'(sb.size()), 64'd0);
      @(negedge clk);
      check_eq("mvalid_single_pulse", 64'(mv), 64'd0);
      @(posedge clk); #1;
   endtask

   // Output monitor: every consumed result is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] co;
      for (int k = 0; k < 4; k++) begin
         if (rst_n && mv[k] && m_ready) begin
            case (k)
               0:       co = {56'h0, co0};
               1:       co = {32'h0, co1};
               2:       co = {48'h0, co2};
               default: co = {48'h0, co3};
            endcase
            if (sb.size() == 0) begin
               check_eq($sformatf("spurious_mvalid%0d", k), 64'(mv[k]), 64'd0);
            end else begin
               e = sb.pop_front();
               check_eq("sb_dut_id", 64'(k), 64'(e.id));
               if (e.ck_crc) check_eq($sformatf("crc_out%0d", k), co, e.crc);
               if (e.ck_match) check_eq($sformatf("crc_match%0d", k), 64'(cm[k]), 64'(e.match));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sv = 4'b0000; m_ready = 1'b1; d8 = 8'h00; d16 = 16'h0000; sf = 1'b0; sl = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mvalid", 64'(mv), 64'd0);
      check_eq("rst_busy", 64'(bz), 64'd0);
      check_eq("rst_match", 64'(cm), 64'd0);
      check_eq("rst_ready", 64'(sr), 64'hF);
      check_eq("rst_crc8", 64'(co0), 64'h00);
      check_eq("rst_crc32", 64'(co1), 64'h0);
      check_eq("rst_xm16", 64'(co2), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // CRC-8/WCDMA check value
      load_str("123456789");
      push_exp(0, 64'h25, 1'b0, 1'b1, 1'b0);
      send_bytes(0, 1'b1, 1'b1);
      drain();

      // CRC-32 check value, residue accept, residue reject, random frame
      push_exp(1, 64'hCBF43926, 1'b0, 1'b1, 1'b1);
      send_bytes(1, 1'b1, 1'b1);
      drain();
      fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
      push_exp(1, 64'h0, 1'b1, 1'b0, 1'b1);
      send_bytes(1, 1'b1, 1'b1);
      drain();
      fb[3] = fb[3] ^ 8'h10;
      push_exp(1, 64'h0, 1'b0, 1'b0, 1'b1);
      send_bytes(1, 1'b1, 1'b1);
      drain();
      fb.delete();
      for (int i = 0; i < 7; i++) fb.push_back(8'($urandom_range(0, 255)));
      push_exp(1, 64'(m_crc32()), 1'b0, 1'b1, 1'b0);
      send_bytes(1, 1'b1, 1'b1);
      drain();

      // XMODEM: DW=16 beats against the DW=8 build on the same bytes
      load_str("12345678");
      push_exp(2, 64'(m_xmodem()), 1'b0, 1'b1, 1'b0);
      send_beat(2, 16'h3132, 1'b1, 1'b0);
      send_beat(2, 16'h3334, 1'b0, 1'b0);
      send_beat(2, 16'h3536, 1'b0, 1'b0);
      send_beat(2, 16'h3738, 1'b0, 1'b1);
      drain();
      push_exp(3, 64'(m_xmodem()), 1'b0, 1'b1, 1'b0);
      send_bytes(3, 1'b1, 1'b1);
      drain();
      load_str("123456789");
      push_exp(3, 64'h31C3, 1'b0, 1'b1, 1'b0);
      send_bytes(3, 1'b1, 1'b1);
      drain();

      // single-beat frame, then s_first restarting a partial frame
      fb.delete(); fb.push_back(8'h31);
      push_exp(0, 64'(m_crc8()), 1'b0, 1'b1, 1'b0);
      send_bytes(0, 1'b1, 1'b1);
      drain();
      load_str("AB");
      send_bytes(0, 1'b1, 1'b0);
      check_eq("busy_partial", 64'(bz[0]), 64'd1);
      load_str("123456789");
      push_exp(0, 64'h25, 1'b0, 1'b1, 1'b0);
      send_bytes(0, 1'b1, 1'b1);
      drain();

      // backpressure: held result, then consume and accept in the same cycle
      m_ready = 1'b0;
      push_exp(0, 64'h25, 1'b0, 1'b1, 1'b0);
      send_bytes(0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_sready", 64'(sr[0]), 64'd0);
         check_eq("bp_mvalid", 64'(mv[0]), 64'd1);
         check_eq("bp_crc_stable", 64'(co0), 64'h25);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      load_str("9876");
      push_exp(0, 64'(m_crc8()), 1'b0, 1'b1, 1'b0);
      send_beat(0, {8'h00, fb[0]}, 1'b1, 1'b0);
      check_eq("bp_same_cycle_accept", 64'(bz[0]), 64'd1);
      for (int i = 1; i < 4; i++) send_beat(0, {8'h00, fb[i]}, 1'b0, i == 3);
      drain();

      // async reset mid-frame
      load_str("1234");
      send_bytes(0, 1'b1, 1'b0);
      check_eq("pre_rst_busy", 64'(bz[0]), 64'd1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_run_busy", 64'(bz[0]), 64'd0);
      check_eq("rst_run_mvalid", 64'(mv[0]), 64'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // async reset while a result is held
      m_ready = 1'b0;
      load_str("12");
      send_bytes(0, 1'b1, 1'b1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_done_mvalid", 64'(mv[0]), 64'd0);
      check_eq("rst_done_crc", 64'(co0), 64'h00);
      #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      load_str("123456789");
      push_exp(0, 64'h25, 1'b0, 1'b1, 1'b0);
      send_bytes(0, 1'b1, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
